// File: rtl/result_monitor.sv
// result_monitor
// Watches the core's data-memory write port, records the words written to a
// small window of result slots, and once the program exits (or hangs) compares
// them with a table of expected values to give a single pass/fail verdict.
// It also counts cache accesses and hits per channel while the program runs.
module result_monitor #(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int          NUM_SLOTS      = 8,
    parameter int unsigned BASE_ADDR      = 32'h1000,
    parameter int          NUM_CH         = 2,
    parameter int          CNT_W          = 32,
    parameter int          DRAIN_CYCLES   = 10,
    parameter int          TIMEOUT_CYCLES = 5000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mem_wen,
    input  logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_wdata,
    input  logic                         exit_i,
    input  logic                         cfg_wen,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_idx,
    input  logic [DATA_W-1:0]            cfg_data,
    input  logic [NUM_SLOTS-1:0]         slot_en,
    input  logic [NUM_CH-1:0]            cache_acc,
    input  logic [NUM_CH-1:0]            cache_hit,
    input  logic [$clog2(NUM_SLOTS)-1:0] rd_idx,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timed_out,
    output logic [NUM_SLOTS-1:0]         written,
    output logic [NUM_SLOTS-1:0]         mismatch,
    output logic [$clog2(NUM_SLOTS)-1:0] first_fail,
    output logic [CNT_W-1:0]             cycle_cnt,
    output logic [NUM_CH*CNT_W-1:0]      acc_cnt,
    output logic [NUM_CH*CNT_W-1:0]      hit_cnt
);

    localparam int IDX_W   = $clog2(NUM_SLOTS);
    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [ADDR_W-1:0]  BASE         = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]  SPAN         = ADDR_W'(4 * NUM_SLOTS);
    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD   = DRAIN_W'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0]     cycleCnt_q, cycleCnt_d;
    logic                 timedOut_q, timedOut_d;

    logic [DATA_W-1:0]    captured_q [NUM_SLOTS];
    logic [DATA_W-1:0]    expected_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] written_q;
    logic [DATA_W-1:0]    rdData_q;

    logic [NUM_SLOTS-1:0] mismatch_c, mismatch_q;
    logic [IDX_W-1:0]     firstFail_c, firstFail_q;
    logic                 pass_q;

    logic [CNT_W-1:0]     acc_q [NUM_CH];
    logic [CNT_W-1:0]     hit_q [NUM_CH];

    logic                 active;
    logic [ADDR_W-1:0]    addrOff;
    logic                 addrHit;
    logic [IDX_W-1:0]     hitIdx;

    // Counters stop at all-ones instead of wrapping back to a small value
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v,
                                               input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    // Capture and counting happen only while the program runs or drains
    assign active  = (state_q == S_RUN) || (state_q == S_DRAIN);

    // A write lands in a slot only when it is word aligned inside the window
    assign addrOff = mem_addr - BASE;
    assign addrHit = mem_wen && (mem_addr >= BASE) && (addrOff < SPAN)
                     && (mem_addr[1:0] == 2'b00);
    assign hitIdx  = addrOff[IDX_W+1:2];

    // State register plus the run bookkeeping that travels with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            drain_q    <= '0;
            cycleCnt_q <= '0;
            timedOut_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            cycleCnt_q <= cycleCnt_d;
            timedOut_q <= timedOut_d;
        end
    end

    // Next-state logic: exit beats timeout, drain lets late writes settle
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        cycleCnt_d = cycleCnt_q;
        timedOut_d = timedOut_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    cycleCnt_d = '0;
                end
            end
            S_RUN: begin
                cycleCnt_d = satInc(cycleCnt_q, 1'b1);
                if (exit_i) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end else if (cycleCnt_q == TIMEOUT_LAST) begin
                    timedOut_d = 1'b1;
                    state_d    = S_CHECK;
                end
            end
            S_DRAIN: begin
                cycleCnt_d = satInc(cycleCnt_q, 1'b1);
                drain_d    = drain_q - DRAIN_W'(1);
                if (drain_q <= DRAIN_W'(1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Expected table is only programmable while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                expected_q[i] <= '0;
            end
        end else if ((state_q == S_IDLE) && cfg_wen) begin
            expected_q[cfg_idx] <= cfg_data;
        end
    end

    // Result capture: the last write to a slot wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                captured_q[i] <= '0;
            end
            written_q <= '0;
        end else if (active && addrHit) begin
            captured_q[hitIdx] <= mem_wdata;
            written_q[hitIdx]  <= 1'b1;
        end
    end

    // Registered read-back of a captured slot, usable in any state
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= captured_q[rd_idx];
        end
    end

    // Slot comparison and lowest-index failure search
    always_comb begin
        mismatch_c  = '0;
        firstFail_c = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            mismatch_c[i] = slot_en[i]
                            & (~written_q[i] | (captured_q[i] != expected_q[i]));
        end
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mismatch_c[i]) begin
                firstFail_c = IDX_W'(i);
            end
        end
    end

    // Verdict is latched once in CHECK and then frozen until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q  <= '0;
            firstFail_q <= '0;
            pass_q      <= 1'b0;
        end else if (state_q == S_CHECK) begin
            mismatch_q  <= mismatch_c;
            firstFail_q <= firstFail_c;
            pass_q      <= ~|mismatch_c & ~timedOut_q;
        end
    end

    // Per-channel cache statistics; a hit without an access is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
                hit_q[c] <= '0;
            end
        end else if (active) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= satInc(acc_q[c], cache_acc[c]);
                hit_q[c] <= satInc(hit_q[c], cache_acc[c] & cache_hit[c]);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
        assign acc_cnt[c*CNT_W +: CNT_W] = acc_q[c];
        assign hit_cnt[c*CNT_W +: CNT_W] = hit_q[c];
    end

    assign rd_data    = rdData_q;
    assign busy       = active;
    assign done       = (state_q == S_DONE);
    assign pass       = pass_q;
    assign timed_out  = timedOut_q;
    assign written    = written_q;
    assign mismatch   = mismatch_q;
    assign first_fail = firstFail_q;
    assign cycle_cnt  = cycleCnt_q;

endmodule

// File: tb/tb_result_monitor.sv
// Directed bench for result_monitor: each run pushes its expected verdict onto
// a scoreboard queue, which is popped and compared once the monitor is done.
module tb_result_monitor;

    localparam int DRAIN   = 10;
    localparam int TIMEOUT = 5000;
    localparam int BASE    = 32'h1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        exit_i;
    logic        cfg_wen;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_data;
    logic [7:0]  slot_en;
    logic [1:0]  cache_acc;
    logic [1:0]  cache_hit;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timed_out;
    logic [7:0]  written;
    logic [7:0]  mismatch;
    logic [2:0]  first_fail;
    logic [31:0] cycle_cnt;
    logic [63:0] acc_cnt;
    logic [63:0] hit_cnt;

    typedef struct {
        logic        passV;
        logic        tmoV;
        logic [7:0]  mismV;
        logic [2:0]  ffV;
        logic [7:0]  wrV;
        logic        chkCyc;
        logic [31:0] cycV;
    } verdict_t;

    verdict_t sbQ[$];
    int compared   = 0;
    int mismatched = 0;
    int vals[8]    = '{25, 30, 40, 5, 25, 24, 28, 20};

    result_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .exit_i     (exit_i),
        .cfg_wen    (cfg_wen),
        .cfg_idx    (cfg_idx),
        .cfg_data   (cfg_data),
        .slot_en    (slot_en),
        .cache_acc  (cache_acc),
        .cache_hit  (cache_hit),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .timed_out  (timed_out),
        .written    (written),
        .mismatch   (mismatch),
        .first_fail (first_fail),
        .cycle_cnt  (cycle_cnt),
        .acc_cnt    (acc_cnt),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        mem_wen   = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        tick();
        mem_wen   = 1'b0;
    endtask

    task automatic programTable(input int v[8]);
        for (int i = 0; i < 8; i++) begin
            cfg_wen  = 1'b1;
            cfg_idx  = 3'(i);
            cfg_data = v[i];
            tick();
        end
        cfg_wen = 1'b0;
    endtask

    task automatic startRun();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulseExit();
        exit_i = 1'b1;
        tick();
        exit_i = 1'b0;
    endtask

    task automatic readSlot(input int idx, output logic [31:0] v);
        rd_idx = 3'(idx);
        tick();
        v = rd_data;
    endtask

    task automatic waitDone(input int budget, output int n);
        n = 0;
        while ((done !== 1'b1) && (n < budget)) begin
            tick();
            n++;
        end
        checkOutput("done_reached", {63'd0, done}, 64'd1);
    endtask

    task automatic pushVerdict(input logic p, input logic t, input logic [7:0] m,
                               input logic [2:0] f, input logic [7:0] w,
                               input logic cc, input logic [31:0] cy);
        verdict_t v;
        v.passV  = p;
        v.tmoV   = t;
        v.mismV  = m;
        v.ffV    = f;
        v.wrV    = w;
        v.chkCyc = cc;
        v.cycV   = cy;
        sbQ.push_back(v);
    endtask

    task automatic checkVerdict(input string tag);
        verdict_t v;
        if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            v = sbQ.pop_front();
            checkOutput({tag, "_pass"}, {63'd0, pass}, {63'd0, v.passV});
            checkOutput({tag, "_timed_out"}, {63'd0, timed_out}, {63'd0, v.tmoV});
            checkOutput({tag, "_mismatch"}, {56'd0, mismatch}, {56'd0, v.mismV});
            checkOutput({tag, "_first_fail"}, {61'd0, first_fail}, {61'd0, v.ffV});
            checkOutput({tag, "_written"}, {56'd0, written}, {56'd0, v.wrV});
            if (v.chkCyc) begin
                checkOutput({tag, "_cycle_cnt"}, {32'd0, cycle_cnt}, {32'd0, v.cycV});
            end
        end
    endtask

    task automatic writeAll(input logic [7:0] skip);
        for (int i = 0; i < 8; i++) begin
            if (!skip[i]) begin
                applyStimulus(32'(BASE + 4 * i), vals[i]);
            end
        end
    endtask

    // Directed sequence of scenarios
    initial begin
        int n;
        int guard;
        logic [31:0] rv;

        rst = 1'b1; start = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
        exit_i = 1'b0; cfg_wen = 1'b0; cfg_idx = '0; cfg_data = '0; slot_en = '0;
        cache_acc = '0; cache_hit = '0; rd_idx = '0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_pass", {63'd0, pass}, 64'd0);
        checkOutput("rst_written", {56'd0, written}, 64'd0);
        checkOutput("rst_cycle", {32'd0, cycle_cnt}, 64'd0);
        checkOutput("rst_rd_data", {32'd0, rd_data}, 64'd0);

        // All slots written correctly, exit, drain, pass
        programTable(vals);
        slot_en = 8'hFF;
        pushVerdict(1'b1, 1'b0, 8'h00, 3'd0, 8'hFF, 1'b1, 32'd19);
        startRun();
        checkOutput("s1_busy", {63'd0, busy}, 64'd1);
        writeAll(8'h00);
        pulseExit();
        waitDone(50, n);
        checkOutput("s1_latency", 64'(n), 64'(DRAIN + 1));
        checkVerdict("s1");
        readSlot(0, rv);
        checkOutput("s1_rd0", {32'd0, rv}, 64'd25);
        readSlot(2, rv);
        checkOutput("s1_rd2", {32'd0, rv}, 64'd40);
        readSlot(7, rv);
        checkOutput("s1_rd7", {32'd0, rv}, 64'd20);
        startRun();
        tick();
        checkOutput("s1_done_hold", {63'd0, done}, 64'd1);
        checkOutput("s1_busy_done", {63'd0, busy}, 64'd0);

        // Slot 2 rewritten with the right value: last write wins
        doReset();
        programTable(vals);
        slot_en = 8'hFF;
        pushVerdict(1'b1, 1'b0, 8'h00, 3'd0, 8'hFF, 1'b0, 32'd0);
        startRun();
        applyStimulus(32'h1008, 32'd41);
        writeAll(8'h04);
        applyStimulus(32'h1008, 32'd40);
        pulseExit();
        waitDone(50, n);
        checkVerdict("s2a");

        // Slot 2 only holds the wrong value
        doReset();
        programTable(vals);
        slot_en = 8'hFF;
        pushVerdict(1'b0, 1'b0, 8'h04, 3'd2, 8'hFF, 1'b0, 32'd0);
        startRun();
        writeAll(8'h04);
        applyStimulus(32'h1008, 32'd41);
        pulseExit();
        waitDone(50, n);
        checkVerdict("s2b");
        readSlot(2, rv);
        checkOutput("s2b_rd2", {32'd0, rv}, 64'd41);

        // Slot 5 never written, enabled then masked off
        doReset();
        programTable(vals);
        slot_en = 8'hFF;
        pushVerdict(1'b0, 1'b0, 8'h20, 3'd5, 8'hDF, 1'b0, 32'd0);
        startRun();
        writeAll(8'h20);
        pulseExit();
        waitDone(50, n);
        checkVerdict("s3a");
        readSlot(5, rv);
        checkOutput("s3a_rd5_unwritten", {32'd0, rv}, 64'd0);

        doReset();
        programTable(vals);
        slot_en = 8'hDF;
        pushVerdict(1'b1, 1'b0, 8'h00, 3'd0, 8'hDF, 1'b0, 32'd0);
        startRun();
        writeAll(8'h20);
        pulseExit();
        waitDone(50, n);
        checkVerdict("s3b");

        // No exit: forced timeout
        doReset();
        programTable(vals);
        slot_en = 8'hFF;
        pushVerdict(1'b0, 1'b1, 8'h00, 3'd0, 8'hFF, 1'b1, 32'(TIMEOUT));
        startRun();
        writeAll(8'h00);
        waitDone(TIMEOUT + 100, n);
        checkVerdict("s4a");

        // Exit on the very cycle that would time out
        doReset();
        programTable(vals);
        slot_en = 8'hFF;
        pushVerdict(1'b1, 1'b0, 8'h00, 3'd0, 8'hFF, 1'b1, 32'(TIMEOUT + DRAIN));
        startRun();
        writeAll(8'h00);
        guard = 0;
        while ((cycle_cnt !== 32'(TIMEOUT - 1)) && (guard < TIMEOUT + 100)) begin
            tick();
            guard++;
        end
        checkOutput("s4b_reach_edge", {32'd0, cycle_cnt}, 64'(TIMEOUT - 1));
        pulseExit();
        waitDone(50, n);
        checkOutput("s4b_latency", 64'(n), 64'(DRAIN + 1));
        checkVerdict("s4b");

        // Out-of-window writes, late cfg ignored, drain capture, done freeze
        doReset();
        cfg_wen = 1'b1; cfg_idx = 3'd4; cfg_data = 32'h55;
        tick();
        cfg_wen = 1'b0;
        slot_en = 8'h10;
        pushVerdict(1'b1, 1'b0, 8'h00, 3'd0, 8'h10, 1'b0, 32'd0);
        startRun();
        applyStimulus(32'h0FFC, 32'd1);
        applyStimulus(32'h1020, 32'd2);
        applyStimulus(32'h1002, 32'd3);
        checkOutput("s5_written_none", {56'd0, written}, 64'd0);
        cfg_wen = 1'b1; cfg_idx = 3'd4; cfg_data = 32'h77;
        tick();
        cfg_wen = 1'b0;
        pulseExit();
        checkOutput("s5_busy_drain", {63'd0, busy}, 64'd1);
        applyStimulus(32'h1010, 32'h55);
        waitDone(50, n);
        checkVerdict("s5");
        applyStimulus(32'h1010, 32'h66);
        readSlot(4, rv);
        checkOutput("s5_rd4_frozen", {32'd0, rv}, 64'h55);

        // Cache counters, then reset in the middle of a run
        doReset();
        cache_acc = 2'b11; cache_hit = 2'b11;
        tick();
        tick();
        cache_acc = 2'b00; cache_hit = 2'b00;
        startRun();
        for (int i = 0; i < 10; i++) begin
            cache_acc = 2'b01;
            cache_hit = (i < 7) ? 2'b01 : 2'b00;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            cache_acc = 2'b00;
            cache_hit = 2'b01;
            tick();
        end
        cache_acc = 2'b00; cache_hit = 2'b00;
        checkOutput("s6_acc", acc_cnt, 64'd10);
        checkOutput("s6_hit", hit_cnt, 64'd7);
        checkOutput("s6_cycle", {32'd0, cycle_cnt}, 64'd13);
        applyStimulus(32'h1000, 32'h99);
        readSlot(0, rv);
        checkOutput("s6_rd0", {32'd0, rv}, 64'h99);
        checkOutput("s6_written", {56'd0, written}, 64'h01);
        doReset();
        checkOutput("s6_rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("s6_rst_done", {63'd0, done}, 64'd0);
        checkOutput("s6_rst_written", {56'd0, written}, 64'd0);
        checkOutput("s6_rst_cycle", {32'd0, cycle_cnt}, 64'd0);
        checkOutput("s6_rst_acc", acc_cnt, 64'd0);
        checkOutput("s6_rst_hit", hit_cnt, 64'd0);
        checkOutput("s6_rst_rd", {32'd0, rd_data}, 64'd0);
        checkOutput("s6_rst_tmo", {63'd0, timed_out}, 64'd0);
        tick();
        checkOutput("s6_idle_busy", {63'd0, busy}, 64'd0);
        checkOutput("s6_idle_done", {63'd0, done}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
